// File: rtl/ixu_execute_mdu.sv
// ixu_execute_mdu: integer execute stage for one VLIW integer lane.
// Registered ALU, pipelined multiplier and iterative restoring divider behind
// a valid/ready handshake, with a destination tag and an illegal-op flag.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   flush                     drop any in-flight op and the output register
//   in_valid / in_ready       input handshake
//   is_rs1_fwd, rs1_fwd_data, rs1_data      X operand sources
//   is_rs2_fwd, rs2_fwd_data, rs2_data      Y operand sources
//   imm, is_imm_type          sign-extended immediate replaces Y
//   is_nop, op, in_tag        operation control and passthrough tag
//   out_valid / out_ready     output handshake
//   out_result, out_tag, out_illegal        registered result
module ixu_execute_mdu #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned IMM_W   = 12,
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             is_rs1_fwd,
  input  logic             is_rs2_fwd,
  input  logic [XLEN-1:0]  rs1_fwd_data,
  input  logic [XLEN-1:0]  rs2_fwd_data,
  input  logic [XLEN-1:0]  rs1_data,
  input  logic [XLEN-1:0]  rs2_data,
  input  logic [IMM_W-1:0] imm,
  input  logic             is_imm_type,
  input  logic             is_nop,
  input  logic [3:0]       op,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
);

  localparam int unsigned SHW   = $clog2(XLEN);
  localparam int unsigned CNT_W = $clog2(((XLEN > MUL_LAT) ? XLEN : MUL_LAT) + 1);
  localparam logic [XLEN-1:0] ILL_PAT = {(XLEN/32){32'hDEADBEEF}};

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       op_q, op_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic [XLEN-1:0]  opa_q, opa_d;   // MUL: X; DIV: |X| shifting out, quotient shifting in
  logic [XLEN-1:0]  opb_q, opb_d;   // MUL: Y; DIV: |Y|
  logic [XLEN-1:0]  rem_q, rem_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;
  logic             ov_q, ov_d, ill_q, ill_d;
  logic [XLEN-1:0]  res_q, res_d;
  logic [TAG_W-1:0] otag_q, otag_d;

  logic [XLEN-1:0]   x, y, alu_res, mul_a, mul_b, mul_res, div_res, x_abs, y_abs;
  logic [2*XLEN-1:0] prod;
  logic [3:0]        mop;
  logic [SHW-1:0]    shamt;
  logic [XLEN:0]     shifted;
  logic              ge, accept, load_ok, illegal, is_mul, is_div, sgn_op;

  assign x = is_rs1_fwd ? rs1_fwd_data : rs1_data;
  assign y = is_imm_type ? {{(XLEN-IMM_W){imm[IMM_W-1]}}, imm}
                         : (is_rs2_fwd ? rs2_fwd_data : rs2_data);
  assign shamt = y[SHW-1:0];

  assign is_mul  = (op == 4'hA) || (op == 4'hB);
  assign is_div  = (op >= 4'hC);
  assign illegal = is_imm_type && (op >= 4'hA);
  assign sgn_op  = (op == 4'hC) || (op == 4'hE);
  assign x_abs   = (sgn_op && x[XLEN-1]) ? -x : x;
  assign y_abs   = (sgn_op && y[XLEN-1]) ? -y : y;

  assign in_ready = (state_q == S_IDLE) && (!ov_q || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign load_ok  = !ov_q || out_ready;

  always_comb begin
    alu_res = '0;
    case (op)
      4'h0: alu_res = x + y;
      4'h1: alu_res = x - y;
      4'h2: alu_res = x ^ y;
      4'h3: alu_res = x | y;
      4'h4: alu_res = x & y;
      4'h5: alu_res = x << shamt;
      4'h6: alu_res = x >> shamt;
      4'h7: alu_res = XLEN'($signed(x) >>> shamt);
      4'h8: alu_res = {{(XLEN-1){1'b0}}, ($signed(x) < $signed(y))};
      4'h9: alu_res = {{(XLEN-1){1'b0}}, (x < y)};
      default: alu_res = '0;
    endcase
  end

  // The multiplier is fed from the live operands in IDLE (single-cycle latency
  // case) and from the captured operands otherwise.
  assign mul_a = (state_q == S_IDLE) ? x  : opa_q;
  assign mul_b = (state_q == S_IDLE) ? y  : opb_q;
  assign mop   = (state_q == S_IDLE) ? op : op_q;
  assign prod  = {{XLEN{mul_a[XLEN-1]}}, mul_a} * {{XLEN{mul_b[XLEN-1]}}, mul_b};
  assign mul_res = (mop == 4'hA) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];

  // Restoring step: shift next dividend bit into the partial remainder.
  assign shifted = {rem_q, opa_q[XLEN-1]};
  assign ge      = shifted >= {1'b0, opb_q};

  // Divide-by-zero leaves quotient all-ones and remainder |X|; the remainder
  // sign fix then recovers X, so only signed DIV needs an explicit override.
  always_comb begin
    div_res = '0;
    case (op_q)
      4'hC:    div_res = dz_q ? '1 : (qneg_q ? -opa_q : opa_q);
      4'hD:    div_res = opa_q;
      4'hE:    div_res = rneg_q ? -rem_q : rem_q;
      default: div_res = rem_q;
    endcase
  end

  always_comb begin
    state_d = state_q;  cnt_d  = cnt_q;   op_d   = op_q;   tag_d = tag_q;
    opa_d   = opa_q;    opb_d  = opb_q;   rem_d  = rem_q;
    qneg_d  = qneg_q;   rneg_d = rneg_q;  dz_d   = dz_q;
    ov_d    = ov_q && !out_ready;
    res_d   = res_q;    otag_d = otag_q;  ill_d  = ill_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          tag_d = in_tag;
          op_d  = op;
          if (is_nop) begin
            ov_d = 1'b1; res_d = '0; otag_d = in_tag; ill_d = 1'b0;
          end else if (illegal) begin
            ov_d = 1'b1; res_d = ILL_PAT; otag_d = in_tag; ill_d = 1'b1;
          end else if (is_mul) begin
            opa_d = x;
            opb_d = y;
            if (MUL_LAT == 1) begin
              ov_d = 1'b1; res_d = mul_res; otag_d = in_tag; ill_d = 1'b0;
            end else begin
              state_d = S_MUL;
              cnt_d   = CNT_W'(MUL_LAT - 1);
            end
          end else if (is_div) begin
            state_d = S_DIV;
            cnt_d   = CNT_W'(XLEN);
            opa_d   = x_abs;
            opb_d   = y_abs;
            rem_d   = '0;
            qneg_d  = sgn_op && (x[XLEN-1] ^ y[XLEN-1]);
            rneg_d  = sgn_op && x[XLEN-1];
            dz_d    = (y == '0);
          end else begin
            ov_d = 1'b1; res_d = alu_res; otag_d = in_tag; ill_d = 1'b0;
          end
        end
      end
      S_MUL: begin
        if (cnt_q > CNT_W'(1)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else if (load_ok) begin
          ov_d = 1'b1; res_d = mul_res; otag_d = tag_q; ill_d = 1'b0;
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      end
      S_DIV: begin
        rem_d = ge ? XLEN'(shifted - {1'b0, opb_q}) : shifted[XLEN-1:0];
        opa_d = {opa_q[XLEN-2:0], ge};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = S_FIX;
      end
      default: begin
        if (load_ok) begin
          ov_d = 1'b1; res_d = div_res; otag_d = tag_q; ill_d = 1'b0;
          state_d = S_IDLE;
        end
      end
    endcase
    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      ov_d    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE; cnt_q  <= '0; op_q   <= '0; tag_q <= '0;
      opa_q   <= '0;     opb_q  <= '0; rem_q  <= '0;
      qneg_q  <= 1'b0;   rneg_q <= 1'b0; dz_q <= 1'b0;
      ov_q    <= 1'b0;   res_q  <= '0; otag_q <= '0; ill_q <= 1'b0;
    end else begin
      state_q <= state_d; cnt_q  <= cnt_d;  op_q   <= op_d;   tag_q <= tag_d;
      opa_q   <= opa_d;   opb_q  <= opb_d;  rem_q  <= rem_d;
      qneg_q  <= qneg_d;  rneg_q <= rneg_d; dz_q   <= dz_d;
      ov_q    <= ov_d;    res_q  <= res_d;  otag_q <= otag_d; ill_q <= ill_d;
    end
  end

  assign out_valid   = ov_q;
  assign out_result  = res_q;
  assign out_tag     = otag_q;
  assign out_illegal = ill_q;

endmodule

// File: tb/tb_ixu_execute_mdu.sv
// Directed self-checking bench for ixu_execute_mdu (XLEN=32, MUL_LAT=2).
module tb_ixu_execute_mdu;

  localparam int XLEN    = 32;
  localparam int IMM_W   = 12;
  localparam int TAG_W   = 5;
  localparam int MUL_LAT = 2;

  logic             clk, rst, flush, in_valid, in_ready;
  logic             is_rs1_fwd, is_rs2_fwd, is_imm_type, is_nop;
  logic [XLEN-1:0]  rs1_fwd_data, rs2_fwd_data, rs1_data, rs2_data;
  logic [IMM_W-1:0] imm;
  logic [3:0]       op;
  logic [TAG_W-1:0] in_tag, out_tag;
  logic             out_valid, out_ready, out_illegal;
  logic [XLEN-1:0]  out_result;

  int n_checks = 0;
  int n_fail   = 0;

  ixu_execute_mdu #(.XLEN(XLEN), .IMM_W(IMM_W), .TAG_W(TAG_W), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .is_rs1_fwd(is_rs1_fwd), .is_rs2_fwd(is_rs2_fwd),
    .rs1_fwd_data(rs1_fwd_data), .rs2_fwd_data(rs2_fwd_data),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .imm(imm), .is_imm_type(is_imm_type), .is_nop(is_nop),
    .op(op), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag), .out_illegal(out_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic set_rr(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] t);
    op = o; rs1_data = a; rs2_data = b; in_tag = t;
    is_rs1_fwd = 1'b0; is_rs2_fwd = 1'b0; is_imm_type = 1'b0; is_nop = 1'b0;
    rs1_fwd_data = '0; rs2_fwd_data = '0; imm = '0;
  endtask

  // Presents the current operand setup for one cycle, then counts cycles until
  // out_valid (bounded). rdy_bad is set if in_ready was high while waiting.
  task automatic run_op(output int cyc, output bit rdy_bad);
    @(negedge clk);
    in_valid = 1'b1;
    cyc = 0;
    rdy_bad = 1'b0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      cyc++;
      #1;
      if (!out_valid && in_ready) rdy_bad = 1'b1;
    end while (!out_valid && cyc < 200);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_rr(4'h0, 32'h0, 32'h0, 5'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: out_valid=%b out_illegal=%b required 0 0", out_valid, out_illegal);
    end
    n_checks++;
    if (out_result !== 32'h0 || out_tag !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_data: result=%h tag=%0d required 0 0", out_result, out_tag);
    end
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_fwd_imm();
    int cyc;
    bit rb;
    set_rr(4'h0, 32'd5, 32'd100, 5'd9);
    rs1_fwd_data = 32'd7; is_rs1_fwd = 1'b1; imm = 12'hFFF; is_imm_type = 1'b1;
    run_op(cyc, rb);
    n_checks++;
    if (cyc !== 1 || out_result !== 32'd6 || out_tag !== 5'd9 || out_illegal !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_imm_add: cyc=%0d result=%h tag=%0d ill=%b required 1 00000006 9 0",
               cyc, out_result, out_tag, out_illegal);
    end
    set_rr(4'h0, 32'd5, 32'd100, 5'd10);
    rs2_fwd_data = 32'd10; is_rs2_fwd = 1'b1;
    run_op(cyc, rb);
    n_checks++;
    if (cyc !== 1 || out_result !== 32'd15 || out_tag !== 5'd10) begin
      n_fail++;
      $display("FAIL fwd_rs2_add: cyc=%0d result=%h tag=%0d required 1 0000000f 10", cyc, out_result, out_tag);
    end
  endtask

  // ALU, NOP and illegal ops issued back to back with out_ready high.
  task automatic test_alu_stream();
    localparam int N = 12;
    logic [3:0]  v_op [N] = '{4'h0, 4'h1, 4'h7, 4'h6, 4'h5, 4'h9, 4'h8, 4'h0, 4'hC, 4'h2, 4'h4, 4'h8};
    logic [31:0] v_a  [N] = '{32'hFFFFFFFF, 32'd3, 32'h80000000, 32'h80000000, 32'd1, 32'd1, 32'd1,
                              32'd3, 32'd9, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'hFFFFFFFE};
    logic [31:0] v_b  [N] = '{32'd1, 32'd5, 32'd33, 32'd33, 32'd31, 32'hFFFFFFFF, 32'hFFFFFFFF,
                              32'd4, 32'd5, 32'hFF00FF00, 32'hFF00FF00, 32'h00000FFF};
    logic        v_im [N] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1};
    logic        v_np [N] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    logic [31:0] v_ex [N] = '{32'h0, 32'hFFFFFFFE, 32'hC0000000, 32'h40000000, 32'h80000000, 32'd1,
                              32'd0, 32'd0, 32'hDEADBEEF, 32'h0FF00FF0, 32'hF000F000, 32'd1};
    logic        v_il [N] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    logic [31:0] b;
    out_ready = 1'b1;
    for (int i = 0; i <= N; i++) begin
      @(negedge clk);
      if (i < N) begin
        b = v_b[i];
        set_rr(v_op[i], v_a[i], b, 5'(i));
        imm = b[11:0]; is_imm_type = v_im[i]; is_nop = v_np[i];
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (i < N) begin
        n_checks++;
        if (in_ready !== 1'b1) begin
          n_fail++;
          $display("FAIL alu_in_ready[%0d]: got %b required 1", i, in_ready);
        end
      end
      if (i > 0) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_result !== v_ex[i-1] || out_illegal !== v_il[i-1]
            || out_tag !== 5'(i-1)) begin
          n_fail++;
          $display("FAIL alu[%0d]: valid=%b result=%h ill=%b tag=%0d required 1 %h %b %0d",
                   i-1, out_valid, out_result, out_illegal, out_tag, v_ex[i-1], v_il[i-1], i-1);
        end
      end
    end
    is_imm_type = 1'b0; is_nop = 1'b0;
  endtask

  task automatic test_mul();
    logic [3:0]  m_op [2] = '{4'hA, 4'hB};
    logic [31:0] m_ex [2] = '{32'hFFFFFFEB, 32'hFFFFFFFF};
    int cyc;
    bit rb;
    for (int i = 0; i < 2; i++) begin
      set_rr(m_op[i], 32'hFFFFFFFD, 32'd7, 5'(20 + i));
      run_op(cyc, rb);
      n_checks++;
      if (cyc !== MUL_LAT || rb !== 1'b0 || out_result !== m_ex[i] || out_tag !== 5'(20 + i)) begin
        n_fail++;
        $display("FAIL mul[%0d]: cyc=%0d in_ready_seen=%b result=%h tag=%0d required %0d 0 %h %0d",
                 i, cyc, rb, out_result, out_tag, MUL_LAT, m_ex[i], 20 + i);
      end
    end
  endtask

  task automatic test_div();
    localparam int N = 8;
    logic [3:0]  d_op [N] = '{4'hC, 4'hE, 4'hD, 4'hF, 4'hC, 4'hE, 4'hC, 4'hE};
    logic [31:0] d_a  [N] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'h1234, 32'h1234,
                              32'h80000000, 32'h80000000, 32'hFFFFFFFB, 32'hFFFFFFFB};
    logic [31:0] d_b  [N] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 32'd0};
    logic [31:0] d_ex [N] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h1234,
                              32'h80000000, 32'h0, 32'hFFFFFFFF, 32'hFFFFFFFB};
    int cyc;
    bit rb;
    for (int i = 0; i < N; i++) begin
      set_rr(d_op[i], d_a[i], d_b[i], 5'(i + 1));
      run_op(cyc, rb);
      n_checks++;
      if (cyc !== XLEN + 2 || rb !== 1'b0 || out_result !== d_ex[i] || out_tag !== 5'(i + 1)) begin
        n_fail++;
        $display("FAIL div[%0d]: cyc=%0d in_ready_seen=%b result=%h tag=%0d required %0d 0 %h %0d",
                 i, cyc, rb, out_result, out_tag, XLEN + 2, d_ex[i], i + 1);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] got_res [$];
    logic [4:0]  got_tag [$];
    int idx = 0;
    bit will_acc = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (will_acc) idx++;
      out_ready = (k >= 3);
      if (idx < 4) begin
        set_rr(4'h0, 32'(16 * (idx + 1)), 32'd1, 5'(idx + 1));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      #1;
      if (k == 1 || k == 2) begin
        n_checks++;
        if (in_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_in_ready[%0d]: got %b required 0", k, in_ready);
        end
      end
      if (k >= 1 && k <= 3) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_result !== 32'h11 || out_tag !== 5'd1) begin
          n_fail++;
          $display("FAIL bp_hold[%0d]: valid=%b result=%h tag=%0d required 1 00000011 1",
                   k, out_valid, out_result, out_tag);
        end
      end
      if (out_valid && out_ready) begin
        got_res.push_back(out_result);
        got_tag.push_back(out_tag);
      end
      will_acc = in_valid && in_ready;
    end
    n_checks++;
    if (got_res.size() !== 4) begin
      n_fail++;
      $display("FAIL bp_count: got %0d results required 4", got_res.size());
    end
    for (int i = 0; i < got_res.size() && i < 4; i++) begin
      n_checks++;
      if (got_res[i] !== 32'(16 * (i + 1) + 1) || got_tag[i] !== 5'(i + 1)) begin
        n_fail++;
        $display("FAIL bp_order[%0d]: result=%h tag=%0d required %h %0d",
                 i, got_res[i], got_tag[i], 32'(16 * (i + 1) + 1), i + 1);
      end
    end
  endtask

  task automatic test_flush();
    bit stale = 1'b0;
    out_ready = 1'b1;
    set_rr(4'hC, 32'd100, 32'd7, 5'd6);
    @(negedge clk);
    in_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    // Flush at iteration 10 with a competing ADD that must not be accepted.
    flush = 1'b1;
    set_rr(4'h0, 32'd1, 32'd1, 5'd7);
    in_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_next: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    n_checks++;
    if (stale !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_stale: stale result seen=%b required 0", stale);
    end
  endtask

  task automatic test_reset_mid_mul();
    bit stale = 1'b0;
    set_rr(4'hA, 32'd5, 32'd6, 5'd11);
    @(negedge clk);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || out_result !== 32'h0 || out_tag !== 5'd0 || out_illegal !== 1'b0
        || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid_mul: valid=%b result=%h tag=%0d ill=%b in_ready=%b required 0 0 0 0 1",
               out_valid, out_result, out_tag, out_illegal, in_ready);
    end
    for (int k = 0; k < MUL_LAT + 3; k++) begin
      @(negedge clk);
      if (out_valid) stale = 1'b1;
    end
    n_checks++;
    if (stale !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mul_stale: stale result seen=%b required 0", stale);
    end
  endtask

  initial begin
    test_reset();
    test_fwd_imm();
    test_alu_stream();
    test_mul();
    test_div();
    test_backpressure();
    test_flush();
    test_reset_mid_mul();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ixu_execute_mdu.md
# ixu_execute_mdu

Parametrised integer execute stage for one VLIW integer lane. It extends the combinational ALU with a registered output and a valid/ready handshake. It adds a pipelined multiplier and an iterative divider. It carries a destination tag and replaces the simulation-time invalid-op error with a hardware flag. It sits between the IXU operand-read/forwarding stage and IXU writeback.

## Interface
- XLEN, 32: datapath width; legal values 32 or 64.
- IMM_W, 12: immediate width; sign-extended to XLEN.
- TAG_W, 5: width of the passthrough tag (destination register index).
- MUL_LAT, 2: multiply latency in cycles, ≥1.

- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  kill any in-flight op and the output register.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit accepts the operation this cycle.
- is_rs1_fwd / is_rs2_fwd  in  1 each  select forwarded data for rs1 / rs2.
- rs1_fwd_data / rs2_fwd_data  in  XLEN each  forwarded operands.
- rs1_data / rs2_data  in  XLEN each  register-file operands.
- imm  in  IMM_W  immediate.
- is_imm_type  in  1  Y = sext(imm) instead of rs2.
- is_nop  in  1  slot is a NOP.
- op  in  4  operation code (see Operation).
- in_tag  in  TAG_W  tag carried to the output.
- out_valid  out  1  result available.
- out_ready  in  1  writeback consumes the result.
- out_result  out  XLEN  result.
- out_tag  out  TAG_W  tag of the result.
- out_illegal  out  1  result came from an undefined op.

## Operation
- Operand selection:
  - X = is_rs1_fwd ? rs1_fwd_data : rs1_data.
  - Y = is_imm_type ? sext(imm) : (is_rs2_fwd ? rs2_fwd_data : rs2_data).
  - Both are sampled at acceptance.
- Shift amount is Y[log2(XLEN)-1:0] for both register and immediate forms.
- op codes:
  - 0 ADD; 1 SUB; 2 XOR; 3 OR; 4 AND; 5 SLL; 6 SRL; 7 SRA.
  - 8 SLT (signed); 9 SLTU. Both produce 1 or 0, zero-extended.
  - A MUL: low XLEN bits of the product.
  - B MULH: high XLEN bits of the signed×signed product.
  - C DIV; D DIVU; E REM; F REMU.
- is_nop overrides op: result 0, out_illegal 0.
- ADD/SUB wrap modulo 2^XLEN. No overflow flag.
- Divide by zero: DIV/DIVU return all-ones; REM/REMU return X.
- Signed overflow (X = most-negative, Y = -1): DIV returns X; REM returns 0.
- Undefined ops: none at op width 4. The out_illegal path is kept for the is_imm_type + op ≥ A combination, which has no immediate form. That combination gives result 0xDEADBEEF, replicated to XLEN, with out_illegal = 1.
- FSM states:
  - IDLE: accepts the next op.
  - MUL: counter runs MUL_LAT-1 down to 0.
  - DIV: unsigned restoring divide on absolute values, one quotient bit per cycle, XLEN iterations, then a one-cycle sign-fix step.
  - Leaving MUL or DIV writes the output register and returns to IDLE.
- Single-issue, in order: at most one multi-cycle op in flight.

## Timing
- Reset values: out_valid 0, out_result 0, out_tag 0, out_illegal 0, FSM IDLE, counters 0.
- in_ready = (state == IDLE) && (!out_valid || out_ready) && !flush.
- Acceptance happens when in_valid && in_ready, in cycle N.
- Latency from acceptance:
  - ALU op, NOP or illegal: out_valid at N+1.
  - MUL/MULH: out_valid at N+MUL_LAT.
  - DIV family: out_valid at N+XLEN+2, including the sign-fix cycle.
- ALU ops sustain one per cycle while out_ready = 1.
- Output hold: while out_valid && !out_ready, out_result, out_tag and out_illegal stay stable.
- A completing MUL/DIV whose output register is still full stalls in its final state until out_ready.
- A handshake completes when out_valid && out_ready. out_valid drops next cycle unless a new result loads in that same cycle.
- flush, in any state: next cycle out_valid = 0 and FSM = IDLE; the in-flight result is discarded.
  - flush wins over a simultaneous in_valid (the op is not accepted) and over a simultaneous completion.
- rst has priority over flush and restores all reset values, including mid-divide.

## Test plan
- Forwarding/immediate: rs1_data = 5, rs1_fwd_data = 7, is_rs1_fwd = 1, imm = 12'hFFF, is_imm_type = 1, op ADD -> out_result 6 at N+1; out_tag equals in_tag.
- Shifts and compares: X = 0x80000000, Y = 33, op SRA -> 0xC0000000; op SLTU with X = 1, Y = -1 -> 1; op SLT -> 0.
- Multiply: X = -3, Y = 7, MUL -> 0xFFFFFFEB and MULH -> 0xFFFFFFFF, each out_valid exactly MUL_LAT cycles after acceptance; in_ready low in between.
- Divide corners:
  - DIV -7/2 -> -3; REM -> -1.
  - DIVU x/0 -> 0xFFFFFFFF; REMU x/0 -> x.
  - DIV 0x80000000/-1 -> 0x80000000; REM -> 0.
  - Each valid at N+XLEN+2.
- Backpressure: 4 back-to-back ADDs with out_ready held 0 for 3 cycles -> in_ready low, output stable, no result lost or duplicated, all 4 results in order.
- Flush/reset: flush at DIV iteration 10 -> out_valid 0, in_ready 1 the next cycle, no stale result. rst during MUL -> every output at its reset value.
